hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage datapath. It sequences the PC, IF/ID and ID/EX pipeline registers, and it resolves three kinds of hazard: RAW hazards at the ID-stage operand muxes, load-use stalls, and multi-cycle hi/lo (mult/div) occupancy. It sits beside the decode stage. It drives the load enables and flushes of the upstream registers and the bubble request into the ID/EX stage, which zeroes `control_signals` when requested.

---
 rtl/pipeline_pkg.sv | 38 +++
 rtl/hazard_ctrl_md_occupancy.sv | 58 +++++
 rtl/hazard_ctrl.sv | 111 +++++++++++
 tb/tb_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-index width, operand forward selects,
// mult/div occupancy states and the hazard match helpers.
package pipeline_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // A writer hits a source only when both sides are live and the register is not r0.
  function automatic logic reg_match(input logic             src_used,
                                     input logic [REG_W-1:0] src,
                                     input logic             wr_en,
                                     input logic [REG_W-1:0] dest);
    return src_used && wr_en && (dest != '0) && (dest == src);
  endfunction

  function automatic logic [1:0] fwd_select(input logic ex_hit,
                                            input logic mem_hit,
                                            input logic wb_hit);
    if (ex_hit)
      return FWD_EX;
    else if (mem_hit)
      return FWD_MEM;
    else if (wb_hit)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_occupancy.sv
// Mult/div hi/lo occupancy tracker: busy for MD_LATENCY-1 cycles after a
// mult/div leaves its single EX cycle; a restart while busy reloads the count.
module md_occupancy
  import pipeline_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [7:0] LOAD_COUNT = 8'(MD_LATENCY - 1);

  md_state_t  state;
  logic [7:0] count;
  logic       busy_q;

  // Leave BUSY on the edge where the count would reach zero, so md_busy covers
  // exactly MD_LATENCY-1 cycles after the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            state  <= BUSY;
            count  <= LOAD_COUNT;
            busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (md_start) begin
            count <= LOAD_COUNT;
          end else if (count <= 8'd1) begin
            state  <= IDLE;
            count  <= '0;
            busy_q <= 1'b0;
          end else begin
            count <= count - 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          count  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = busy_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and hi/lo stalls,
// taken-branch flush. Define HAZARD_FORWARDING_EN to enable operand forwarding.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_use,
  input  logic             ex_rf_enable,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             mem_rf_enable,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             wb_rf_enable,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             ex_md_start,
  input  logic             ex_branch_taken,
  output logic             pc_le,
  output logic             ifid_le,
  output logic             ifid_flush,
  output logic             idex_nop,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             md_busy,
  output logic [15:0]      stall_cycles
);

  logic md_busy_state;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic ex_match, mem_match, load_use, md_stall, data_stall, stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  md_occupancy #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_occupancy (
    .clk     (clk),
    .reset   (reset),
    .md_start(ex_md_start),
    .md_busy (md_busy_state)
  );

  assign ex_hit_a  = reg_match(id_use_rs, id_rs, ex_rf_enable, ex_dest);
  assign ex_hit_b  = reg_match(id_use_rt, id_rt, ex_rf_enable, ex_dest);
  assign mem_hit_a = reg_match(id_use_rs, id_rs, mem_rf_enable, mem_dest);
  assign mem_hit_b = reg_match(id_use_rt, id_rt, mem_rf_enable, mem_dest);

  assign ex_match  = ex_hit_a | ex_hit_b;
  assign mem_match = mem_hit_a | mem_hit_b;
  assign load_use  = ex_load & ex_match;
  assign md_stall  = md_busy_state & id_md_use;

`ifdef HAZARD_FORWARDING_EN
  logic wb_hit_a, wb_hit_b;

  assign wb_hit_a   = reg_match(id_use_rs, id_rs, wb_rf_enable, wb_dest);
  assign wb_hit_b   = reg_match(id_use_rt, id_rt, wb_rf_enable, wb_dest);
  assign fwd_a_sel  = fwd_select(ex_hit_a, mem_hit_a, wb_hit_a);
  assign fwd_b_sel  = fwd_select(ex_hit_b, mem_hit_b, wb_hit_b);
  assign data_stall = load_use;
`else
  // The register file writes before it reads, so WB never needs a stall here.
  logic unused_wb;

  assign unused_wb  = ^{wb_rf_enable, wb_dest};
  assign fwd_a_sel  = FWD_RF;
  assign fwd_b_sel  = FWD_RF;
  assign data_stall = load_use | ex_match | mem_match;
`endif

  assign stall = data_stall | md_stall;

  // Reset forces a frozen, flushed front end; a taken branch overrides any stall.
  always_comb begin
    pc_le      = 1'b1;
    ifid_le    = 1'b1;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    fwd_a      = fwd_a_sel;
    fwd_b      = fwd_b_sel;
    if (reset) begin
      pc_le      = 1'b0;
      ifid_le    = 1'b0;
      ifid_flush = 1'b1;
      idex_nop   = 1'b1;
      fwd_a      = FWD_RF;
      fwd_b      = FWD_RF;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
    end else if (stall) begin
      pc_le    = 1'b0;
      ifid_le  = 1'b0;
      idex_nop = 1'b1;
    end
  end

  assign md_busy = md_busy_state & ~reset;

  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (!pc_le && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand sequences for
// multi-cycle cases, and randomized cycles against a rule-level reference model.
module tb_hazard_ctrl;

  localparam int unsigned LAT = 4;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, md_use;
    logic       ex_rf, ex_load;
    logic [4:0] ex_dest;
    logic       mem_rf;
    logic [4:0] mem_dest;
    logic       wb_rf;
    logic [4:0] wb_dest;
    logic       md_start, br;
  } stim_t;

  typedef struct {
    logic       pc_le, ifid_le, flush, nop;
    logic [1:0] fa, fb;
    logic       busy;
  } exp_t;

  typedef struct {
    string name;
    stim_t s;
    exp_t  e;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest, wb_dest;
  logic id_use_rs, id_use_rt, id_md_use, ex_rf_enable, ex_load;
  logic mem_rf_enable, wb_rf_enable, ex_md_start, ex_branch_taken;
  logic pc_le, ifid_le, ifid_flush, idex_nop, md_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int last_start = -1000;
  int stall_cnt = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_md_use(id_md_use), .ex_rf_enable(ex_rf_enable), .ex_load(ex_load),
    .ex_dest(ex_dest), .mem_rf_enable(mem_rf_enable), .mem_dest(mem_dest),
    .wb_rf_enable(wb_rf_enable), .wb_dest(wb_dest), .ex_md_start(ex_md_start),
    .ex_branch_taken(ex_branch_taken), .pc_le(pc_le), .ifid_le(ifid_le),
    .ifid_flush(ifid_flush), .idex_nop(idex_nop), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rs: 5'd0, rt: 5'd0, use_rs: 1'b0, use_rt: 1'b0, md_use: 1'b0,
          ex_rf: 1'b0, ex_load: 1'b0, ex_dest: 5'd0, mem_rf: 1'b0, mem_dest: 5'd0,
          wb_rf: 1'b0, wb_dest: 5'd0, md_start: 1'b0, br: 1'b0};
    return s;
  endfunction

  function automatic exp_t mk(input logic p, input logic l, input logic f, input logic n,
                              input logic [1:0] a, input logic [1:0] b, input logic bz);
    exp_t e;
    e = '{pc_le: p, ifid_le: l, flush: f, nop: n, fa: a, fb: b, busy: bz};
    return e;
  endfunction

  task automatic applyStimulus(input stim_t s);
    reset = s.rst; id_rs = s.rs; id_rt = s.rt; id_use_rs = s.use_rs; id_use_rt = s.use_rt;
    id_md_use = s.md_use; ex_rf_enable = s.ex_rf; ex_load = s.ex_load; ex_dest = s.ex_dest;
    mem_rf_enable = s.mem_rf; mem_dest = s.mem_dest; wb_rf_enable = s.wb_rf;
    wb_dest = s.wb_dest; ex_md_start = s.md_start; ex_branch_taken = s.br;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: writers ranked EX, MEM, WB; hi/lo busy from the last start edge.
  task automatic model_eval(input stim_t s, output exp_t e);
    logic [4:0] dst [3];
    logic       en  [3];
    int  fa_src, fb_src, age;
    bit  haz, busy, stall;
    dst = '{s.ex_dest, s.mem_dest, s.wb_dest};
    en  = '{s.ex_rf, s.mem_rf, s.wb_rf};
    fa_src = 0;
    fb_src = 0;
    for (int w = 2; w >= 0; w--) begin
      if (s.use_rs && en[w] && dst[w] != 0 && dst[w] == s.rs) fa_src = w + 1;
      if (s.use_rt && en[w] && dst[w] != 0 && dst[w] == s.rt) fb_src = w + 1;
    end
    if (FWD_ON)
      haz = s.ex_load && (fa_src == 1 || fb_src == 1);
    else
      haz = (fa_src == 1 || fa_src == 2 || fb_src == 1 || fb_src == 2);
    age   = cyc - last_start;
    busy  = (age >= 1) && (age <= int'(LAT) - 1);
    stall = haz || (busy && s.md_use);
    if (!FWD_ON) begin
      fa_src = 0;
      fb_src = 0;
    end
    if (s.rst)
      e = mk(0, 0, 1, 1, 2'd0, 2'd0, 0);
    else if (s.br)
      e = mk(1, 1, 1, 0, 2'(fa_src), 2'(fb_src), busy);
    else if (stall)
      e = mk(0, 0, 0, 1, 2'(fa_src), 2'(fb_src), busy);
    else
      e = mk(1, 1, 0, 0, 2'(fa_src), 2'(fb_src), busy);
  endtask

  task automatic model_edge(input stim_t s, input exp_t e);
    if (s.rst) begin
      last_start = -1000;
      stall_cnt  = 0;
    end else begin
      if (!e.pc_le && stall_cnt < 65535) stall_cnt++;
      if (s.md_start) last_start = cyc;
    end
    cyc++;
  endtask

  task automatic compare_all(input string tag, input exp_t e);
    checkOutput({tag, "/pc_le"}, 16'(pc_le), 16'(e.pc_le));
    checkOutput({tag, "/ifid_le"}, 16'(ifid_le), 16'(e.ifid_le));
    checkOutput({tag, "/ifid_flush"}, 16'(ifid_flush), 16'(e.flush));
    checkOutput({tag, "/idex_nop"}, 16'(idex_nop), 16'(e.nop));
    checkOutput({tag, "/fwd_a"}, 16'(fwd_a), 16'(e.fa));
    checkOutput({tag, "/fwd_b"}, 16'(fwd_b), 16'(e.fb));
    checkOutput({tag, "/md_busy"}, 16'(md_busy), 16'(e.busy));
  endtask

  task automatic run_cycle(input stim_t s, input string tag, input bit use_tbl, input exp_t tv);
    exp_t m;
    @(negedge clk);
    applyStimulus(s);
    #1;
    model_eval(s, m);
    compare_all(tag, use_tbl ? tv : m);
    checkOutput({tag, "/stall_cycles"}, stall_cycles, 16'(stall_cnt));
    model_edge(s, m);
  endtask

  task automatic add(input string name, input stim_t s, input exp_t e);
    vec_t v;
    v.name = name;
    v.s = s;
    v.e = e;
    tbl.push_back(v);
  endtask

  initial begin
    stim_t s;
    exp_t  none;
    none = mk(0, 0, 0, 0, 2'd0, 2'd0, 0);

    // Bring the DUT out of its unknown power-up state without checking.
    s = idle();
    s.rst = 1'b1;
    applyStimulus(s);
    repeat (2) @(posedge clk);

    // Directed table: combinational behaviour with hi/lo idle.
    s = idle(); s.rst = 1'b1;
    add("reset", s, mk(0, 0, 1, 1, 2'd0, 2'd0, 0));

    s = idle(); s.ex_rf = 1; s.ex_dest = 5; s.mem_rf = 1; s.mem_dest = 5;
    s.rs = 5; s.use_rs = 1; s.rt = 9; s.use_rt = 1; s.wb_rf = 1; s.wb_dest = 9;
    add("fwd_ex_wb", s, FWD_ON ? mk(1, 1, 0, 0, 2'b01, 2'b11, 0) : mk(0, 0, 0, 1, 2'b00, 2'b00, 0));

    s.ex_dest = 0; s.mem_dest = 0; s.wb_dest = 0; s.rs = 0; s.rt = 0;
    add("fwd_r0", s, mk(1, 1, 0, 0, 2'b00, 2'b00, 0));

    s = idle(); s.ex_load = 1; s.ex_rf = 1; s.ex_dest = 7; s.rt = 7; s.use_rt = 1;
    add("load_use", s, mk(0, 0, 0, 1, 2'b00, FWD_ON ? 2'b01 : 2'b00, 0));

    s = idle(); s.mem_rf = 1; s.mem_dest = 7; s.rt = 7; s.use_rt = 1;
    add("load_mem", s, FWD_ON ? mk(1, 1, 0, 0, 2'b00, 2'b10, 0) : mk(0, 0, 0, 1, 2'b00, 2'b00, 0));

    s = idle(); s.br = 1; s.ex_load = 1; s.ex_rf = 1; s.ex_dest = 7; s.rt = 7; s.use_rt = 1;
    add("branch_over_load", s, mk(1, 1, 1, 0, 2'b00, FWD_ON ? 2'b01 : 2'b00, 0));

    s = idle(); s.mem_rf = 1; s.mem_dest = 3; s.rs = 3; s.use_rs = 1;
    add("mem_a_1", s, FWD_ON ? mk(1, 1, 0, 0, 2'b10, 2'b00, 0) : mk(0, 0, 0, 1, 2'b00, 2'b00, 0));
    add("mem_a_2", s, FWD_ON ? mk(1, 1, 0, 0, 2'b10, 2'b00, 0) : mk(0, 0, 0, 1, 2'b00, 2'b00, 0));

    s = idle(); s.wb_rf = 1; s.wb_dest = 4; s.rs = 4; s.use_rs = 1;
    add("wb_a", s, mk(1, 1, 0, 0, FWD_ON ? 2'b11 : 2'b00, 2'b00, 0));

    s = idle(); s.ex_rf = 1; s.ex_dest = 6; s.rs = 6;
    add("unused_src", s, mk(1, 1, 0, 0, 2'b00, 2'b00, 0));

    s = idle(); s.ex_dest = 6; s.rs = 6; s.use_rs = 1;
    add("no_write", s, mk(1, 1, 0, 0, 2'b00, 2'b00, 0));

    s = idle(); s.rt = 2; s.use_rt = 1; s.ex_rf = 1; s.ex_dest = 2;
    s.mem_rf = 1; s.mem_dest = 2; s.wb_rf = 1; s.wb_dest = 2;
    add("prio_ex", s, FWD_ON ? mk(1, 1, 0, 0, 2'b00, 2'b01, 0) : mk(0, 0, 0, 1, 2'b00, 2'b00, 0));

    s = idle(); s.md_use = 1;
    add("md_use_idle", s, mk(1, 1, 0, 0, 2'b00, 2'b00, 0));

    foreach (tbl[i]) run_cycle(tbl[i].s, tbl[i].name, 1'b1, tbl[i].e);

    // Load-use: one stall cycle, then MEM supplies the value.
    s = idle(); s.rst = 1; run_cycle(s, "lu_rst", 0, none);
    s = idle(); s.ex_load = 1; s.ex_rf = 1; s.ex_dest = 7; s.rt = 7; s.use_rt = 1;
    run_cycle(s, "lu_stall", 0, none);
    checkOutput("lu_stall_pc_le", 16'(pc_le), 16'd0);
    s = idle(); s.mem_rf = 1; s.mem_dest = 7; s.rt = 7; s.use_rt = 1;
    run_cycle(s, "lu_after", 0, none);
    checkOutput("lu_after_fwd_b", 16'(fwd_b), FWD_ON ? 16'd2 : 16'd0);
    s = idle(); run_cycle(s, "lu_done", 0, none);
    checkOutput("lu_stall_cycles", stall_cycles, FWD_ON ? 16'd1 : 16'd2);

    // Hi/lo occupancy with latency 4: busy N+1..N+3.
    s = idle(); s.rst = 1; run_cycle(s, "md_rst", 0, none);
    s = idle(); s.md_start = 1; run_cycle(s, "md_N", 0, none);
    checkOutput("md_busy_N", 16'(md_busy), 16'd0);
    s = idle(); s.md_use = 1;
    for (int k = 1; k <= 3; k++) begin
      run_cycle(s, $sformatf("md_N+%0d", k), 0, none);
      checkOutput($sformatf("md_busy_N+%0d", k), 16'(md_busy), 16'd1);
      checkOutput($sformatf("md_stall_N+%0d", k), 16'(pc_le), 16'd0);
    end
    run_cycle(s, "md_N+4", 0, none);
    checkOutput("md_busy_N+4", 16'(md_busy), 16'd0);
    checkOutput("md_pc_le_N+4", 16'(pc_le), 16'd1);
    checkOutput("md_stall_cycles", stall_cycles, 16'd3);

    // Reset two cycles into BUSY.
    s = idle(); s.md_start = 1; run_cycle(s, "rb_start", 0, none);
    s = idle(); run_cycle(s, "rb_busy", 0, none);
    checkOutput("rb_busy_before", 16'(md_busy), 16'd1);
    s = idle(); s.rst = 1; s.md_use = 1; run_cycle(s, "rb_reset", 0, none);
    checkOutput("rb_reset_flush", 16'(ifid_flush), 16'd1);
    s = idle(); s.md_use = 1; run_cycle(s, "rb_after", 0, none);
    checkOutput("rb_after_busy", 16'(md_busy), 16'd0);
    checkOutput("rb_after_stall_cycles", stall_cycles, 16'd0);

    // Randomized cycles against the reference model.
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst      = ($urandom_range(0, 49) == 0);
      s.rs       = 5'($urandom_range(0, 7));
      s.rt       = 5'($urandom_range(0, 7));
      s.use_rs   = 1'($urandom_range(0, 1));
      s.use_rt   = 1'($urandom_range(0, 1));
      s.md_use   = 1'($urandom_range(0, 1));
      s.ex_rf    = 1'($urandom_range(0, 1));
      s.ex_load  = ($urandom_range(0, 3) == 0);
      s.ex_dest  = 5'($urandom_range(0, 7));
      s.mem_rf   = 1'($urandom_range(0, 1));
      s.mem_dest = 5'($urandom_range(0, 7));
      s.wb_rf    = 1'($urandom_range(0, 1));
      s.wb_dest  = 5'($urandom_range(0, 7));
      s.md_start = ($urandom_range(0, 9) == 0);
      s.br       = ($urandom_range(0, 9) == 0);
      run_cycle(s, $sformatf("rand%0d", n), 0, none);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
